// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX->MEM pipeline register: control-word bit
// positions, skid-buffer occupancy encoding and the entry layout.
package ex_mem_pkg;

  localparam int CTRL_MEMREAD     = 5;
  localparam int CTRL_MEMWRITE    = 4;
  localparam int CTRL_MEMTOREG_HI = 3;
  localparam int CTRL_MEMTOREG_LO = 2;
  localparam int CTRL_REGWRITE    = 1;
  localparam int CTRL_REGDST      = 0;

  // Only the low six bits of the control word carry meaning.
  localparam int CTRL_DEC_W = 6;

  localparam int ENTRY_PC_W    = 32;
  localparam int ENTRY_DATA_W  = 32;
  localparam int ENTRY_RADDR_W = 5;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Default-width entry; the pipeline declares its own parametrised copy
  // with the same field order.
  typedef struct packed {
    logic [CTRL_DEC_W-1:0]    ctrl;
    logic [ENTRY_PC_W-1:0]    pc_plus4;
    logic [ENTRY_DATA_W-1:0]  alu_out;
    logic [ENTRY_DATA_W-1:0]  wdata;
    logic [ENTRY_RADDR_W-1:0] rd;
  } ex_mem_entry_t;

  // A result can be forwarded from EX/MEM only if it writes the register
  // file and is not a load (load data is not available yet).
  function automatic logic fwd_eligible(input logic [CTRL_DEC_W-1:0] ctrl);
    return ctrl[CTRL_REGWRITE] & ~ctrl[CTRL_MEMREAD];
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry valid/ready skid buffer with synchronous flush.
// The head entry drives the output; the skid entry catches the beat that
// arrives while ready is still high because ready is registered.
module pipe_skid_buf
  import ex_mem_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  input  logic         i_flush,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output occ_e         o_state
);

  // Handshake: a beat moves on a rising edge when valid and ready are both
  // high on that side; valid never depends on ready, and ready is a register
  // so an upstream beat offered while ready=1 is always captured.

  occ_e         r_state;
  occ_e         w_state_nxt;
  logic [W-1:0] r_head;
  logic [W-1:0] r_skid;
  logic         r_ready;
  logic         w_accept;
  logic         w_drain;
  logic         w_head_from_in;
  logic         w_head_from_skid;
  logic         w_skid_from_in;

  assign w_accept = i_valid & r_ready;
  assign w_drain  = o_valid & i_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_head_from_in   = 1'b0;
    w_head_from_skid = 1'b0;
    w_skid_from_in   = 1'b0;
    if (i_flush) begin
      w_state_nxt = OCC_EMPTY;
    end else begin
      case (r_state)
        OCC_EMPTY: begin
          if (w_accept) begin
            w_state_nxt    = OCC_ONE;
            w_head_from_in = 1'b1;
          end
        end
        OCC_ONE: begin
          if (w_accept && w_drain) begin
            w_head_from_in = 1'b1;
          end else if (w_accept) begin
            w_state_nxt    = OCC_TWO;
            w_skid_from_in = 1'b1;
          end else if (w_drain) begin
            w_state_nxt = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          // Ready is low here, so only a drain can happen.
          if (w_drain) begin
            w_state_nxt      = OCC_ONE;
            w_head_from_skid = 1'b1;
          end
        end
        default: w_state_nxt = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= OCC_EMPTY;
      r_ready <= 1'b1;
      r_head  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt != OCC_TWO);
      if (w_head_from_in) begin
        r_head <= i_data;
      end else if (w_head_from_skid) begin
        r_head <= r_skid;
      end
      if (w_skid_from_in) begin
        r_skid <= i_data;
      end
    end
  end

  assign o_ready = r_ready;
  assign o_valid = (r_state != OCC_EMPTY);
  assign o_data  = r_head;
  assign o_state = r_state;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline stage: skid-buffered payload, control decode masked by
// valid, forwarding tap for the hazard unit and a saturating stall counter.
module ex_mem_pipe
  import ex_mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 32,
  parameter int RADDR_W = 5,
  parameter int CTRL_W  = 6,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [PC_W-1:0]    in_pc_plus4,
  input  logic [DATA_W-1:0]  in_alu_out,
  input  logic [DATA_W-1:0]  in_wdata,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic [DATA_W-1:0]  alu_out,
  output logic [DATA_W-1:0]  wdata,
  output logic [PC_W-1:0]    pc_plus4,
  output logic [RADDR_W-1:0] rd,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0]  fwd_data,
  output logic [STALL_W-1:0] stall_cnt,
  input  logic               clr_stats,
  output occ_e               dbg_occ
);

  typedef struct packed {
    logic [CTRL_DEC_W-1:0] ctrl;
    logic [PC_W-1:0]       pc_plus4;
    logic [DATA_W-1:0]     alu_out;
    logic [DATA_W-1:0]     wdata;
    logic [RADDR_W-1:0]    rd;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  entry_t             w_in_entry;
  entry_t             w_head;
  logic [ENTRY_W-1:0] w_head_bits;
  logic               w_out_valid;
  logic [STALL_W-1:0] r_stall_cnt;

  if (CTRL_W < CTRL_DEC_W) begin : g_ctrl_w_check
    $error("ex_mem_pipe: CTRL_W must be at least 6");
  end

  // Bits above the decoded field are reserved and deliberately dropped.
  if (CTRL_W > CTRL_DEC_W) begin : g_ctrl_hi
    logic w_unused_ctrl_hi;
    assign w_unused_ctrl_hi = ^in_ctrl[CTRL_W-1:CTRL_DEC_W];
  end

  assign w_in_entry.ctrl     = in_ctrl[CTRL_DEC_W-1:0];
  assign w_in_entry.pc_plus4 = in_pc_plus4;
  assign w_in_entry.alu_out  = in_alu_out;
  assign w_in_entry.wdata    = in_wdata;
  assign w_in_entry.rd       = in_rd;

  pipe_skid_buf #(
    .W (ENTRY_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (reset),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_in_entry),
    .i_flush (flush),
    .o_valid (w_out_valid),
    .i_ready (out_ready),
    .o_data  (w_head_bits),
    .o_state (dbg_occ)
  );

  assign w_head    = entry_t'(w_head_bits);
  assign out_valid = w_out_valid;

  // Masking keeps a bubble from ever writing memory or the register file.
  assign reg_write  = w_out_valid & w_head.ctrl[CTRL_REGWRITE];
  assign mem_read   = w_out_valid & w_head.ctrl[CTRL_MEMREAD];
  assign mem_write  = w_out_valid & w_head.ctrl[CTRL_MEMWRITE];
  assign reg_dst    = w_out_valid & w_head.ctrl[CTRL_REGDST];
  assign mem_to_reg = {2{w_out_valid}} & w_head.ctrl[CTRL_MEMTOREG_HI:CTRL_MEMTOREG_LO];

  assign alu_out  = w_head.alu_out;
  assign wdata    = w_head.wdata;
  assign pc_plus4 = w_head.pc_plus4;
  assign rd       = w_head.rd;

  assign fwd_valid = w_out_valid & fwd_eligible(w_head.ctrl);
  assign fwd_rd    = w_head.rd;
  assign fwd_data  = w_head.alu_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (clr_stats) begin
      r_stall_cnt <= '0;
    end else if (w_out_valid && !out_ready && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + STALL_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for ex_mem_pipe: reset, streaming, backpressure, flush,
// decode/forwarding and stall-counter saturation with hand-computed values.
module tb_ex_mem_pipe;
  import ex_mem_pkg::*;

  localparam int DATA_W  = 32;
  localparam int PC_W    = 32;
  localparam int RADDR_W = 5;
  localparam int CTRL_W  = 8;
  localparam int STALL_W = 4;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [CTRL_W-1:0]  in_ctrl;
  logic [PC_W-1:0]    in_pc_plus4;
  logic [DATA_W-1:0]  in_alu_out;
  logic [DATA_W-1:0]  in_wdata;
  logic [RADDR_W-1:0] in_rd;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic               reg_write;
  logic               mem_read;
  logic               mem_write;
  logic               reg_dst;
  logic [1:0]         mem_to_reg;
  logic [DATA_W-1:0]  alu_out;
  logic [DATA_W-1:0]  wdata;
  logic [PC_W-1:0]    pc_plus4;
  logic [RADDR_W-1:0] rd;
  logic               fwd_valid;
  logic [RADDR_W-1:0] fwd_rd;
  logic [DATA_W-1:0]  fwd_data;
  logic [STALL_W-1:0] stall_cnt;
  logic               clr_stats;
  occ_e               dbg_occ;

  int n_checks;
  int n_errors;

  ex_mem_pipe #(
    .DATA_W  (DATA_W),
    .PC_W    (PC_W),
    .RADDR_W (RADDR_W),
    .CTRL_W  (CTRL_W),
    .STALL_W (STALL_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ctrl     (in_ctrl),
    .in_pc_plus4 (in_pc_plus4),
    .in_alu_out  (in_alu_out),
    .in_wdata    (in_wdata),
    .in_rd       (in_rd),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .reg_write   (reg_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .alu_out     (alu_out),
    .wdata       (wdata),
    .pc_plus4    (pc_plus4),
    .rd          (rd),
    .fwd_valid   (fwd_valid),
    .fwd_rd      (fwd_rd),
    .fwd_data    (fwd_data),
    .stall_cnt   (stall_cnt),
    .clr_stats   (clr_stats),
    .dbg_occ     (dbg_occ)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver: present one beat (or idle) before the next rising edge.
  task automatic drive(input logic v, input logic [CTRL_W-1:0] c,
                       input logic [DATA_W-1:0] a, input logic [RADDR_W-1:0] r);
    in_valid    = v;
    in_ctrl     = c;
    in_alu_out  = a;
    in_pc_plus4 = a + 32'h1000;
    in_wdata    = ~a;
    in_rd       = r;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b0;
    flush     = 1'b0;
    clr_stats = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, '0, '0);
    repeat (2) step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_alu_out", 64'(alu_out), 64'd0);
    check("rst_stall", 64'(stall_cnt), 64'd0);
    reset = 1'b1;
    step();

    // Streaming: 8 back-to-back beats, each visible one edge after accept
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 8'h02, 32'h10 + 32'(k), RADDR_W'(k));
      step();
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_alu", 64'(alu_out), 64'h10 + 64'(k));
      check("stream_rd", 64'(rd), 64'(k));
      check("stream_ready", 64'(in_ready), 64'd1);
    end
    drive(1'b0, 8'h02, 32'h0, 5'd0);
    step();
    check("stream_empty", 64'(out_valid), 64'd0);
    check("stream_hold_alu", 64'(alu_out), 64'h17);
    check("stream_mask_rw", 64'(reg_write), 64'd0);

    // Backpressure: A lands in head, B in skid, C held off until release
    out_ready = 1'b0;
    drive(1'b1, 8'h02, 32'hA, 5'd1);
    step();
    check("bp_a_head", 64'(alu_out), 64'hA);
    check("bp_ready_one", 64'(in_ready), 64'd1);
    check("bp_stall0", 64'(stall_cnt), 64'd0);
    drive(1'b1, 8'h02, 32'hB, 5'd2);
    step();
    check("bp_ready_two", 64'(in_ready), 64'd0);
    check("bp_occ_two", 64'(dbg_occ), 64'(OCC_TWO));
    check("bp_head_a", 64'(alu_out), 64'hA);
    drive(1'b1, 8'h02, 32'hC, 5'd3);
    step();
    check("bp_c_blocked", 64'(in_ready), 64'd0);
    step();
    check("bp_stall3", 64'(stall_cnt), 64'd3);
    check("bp_head_a2", 64'(alu_out), 64'hA);
    out_ready = 1'b1;
    step();
    check("bp_out_b", 64'(alu_out), 64'hB);
    check("bp_ready_back", 64'(in_ready), 64'd1);
    step();
    check("bp_out_c", 64'(alu_out), 64'hC);
    check("bp_out_c_rd", 64'(rd), 64'd3);
    drive(1'b0, 8'h00, 32'h0, 5'd0);
    step();
    check("bp_drained", 64'(out_valid), 64'd0);
    check("bp_stall_final", 64'(stall_cnt), 64'd3);

    // Flush in TWO with a third beat offered: nothing survives
    out_ready = 1'b0;
    drive(1'b1, 8'h10, 32'h21, 5'd4);
    step();
    drive(1'b1, 8'h10, 32'h22, 5'd5);
    step();
    check("fl_pre_mw", 64'(mem_write), 64'd1);
    check("fl_pre_occ", 64'(dbg_occ), 64'(OCC_TWO));
    drive(1'b1, 8'h10, 32'h23, 5'd6);
    flush = 1'b1;
    step();
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_mw", 64'(mem_write), 64'd0);
    check("fl_ready", 64'(in_ready), 64'd1);
    flush = 1'b0;
    drive(1'b0, 8'h00, 32'h0, 5'd0);
    out_ready = 1'b1;
    step();
    check("fl_stays_empty", 64'(out_valid), 64'd0);

    // Flush in ONE with a simultaneous accept discards the new beat
    out_ready = 1'b0;
    drive(1'b1, 8'h02, 32'h31, 5'd7);
    step();
    drive(1'b1, 8'h02, 32'h32, 5'd8);
    flush = 1'b1;
    step();
    check("fl1_valid", 64'(out_valid), 64'd0);
    check("fl1_fwd", 64'(fwd_valid), 64'd0);
    flush = 1'b0;
    drive(1'b0, 8'h00, 32'h0, 5'd0);
    out_ready = 1'b1;
    step();
    check("fl1_empty", 64'(out_valid), 64'd0);

    // Decode and forwarding tap; upper control bits must be ignored
    drive(1'b1, 8'hD0, 32'h40, 5'd3);
    step();
    check("dec_st_mw", 64'(mem_write), 64'd1);
    check("dec_st_fwd", 64'(fwd_valid), 64'd0);
    check("dec_st_rw", 64'(reg_write), 64'd0);
    check("dec_st_wdata", 64'(wdata), 64'hFFFF_FFBF);
    drive(1'b1, 8'h02, 32'h55, 5'd7);
    step();
    check("dec_alu_fwd", 64'(fwd_valid), 64'd1);
    check("dec_alu_rd", 64'(fwd_rd), 64'd7);
    check("dec_alu_data", 64'(fwd_data), 64'h55);
    check("dec_alu_mw", 64'(mem_write), 64'd0);
    check("dec_alu_pc", 64'(pc_plus4), 64'h1055);
    drive(1'b1, 8'h26, 32'h60, 5'd9);
    step();
    check("dec_ld_fwd", 64'(fwd_valid), 64'd0);
    check("dec_ld_mr", 64'(mem_read), 64'd1);
    check("dec_ld_m2r", 64'(mem_to_reg), 64'd1);
    check("dec_ld_rw", 64'(reg_write), 64'd1);
    drive(1'b1, 8'h0B, 32'h61, 5'd10);
    step();
    check("dec_rdst", 64'(reg_dst), 64'd1);
    check("dec_m2r_hi", 64'(mem_to_reg), 64'd2);
    drive(1'b0, 8'h00, 32'h0, 5'd0);
    step();
    check("dec_mask_m2r", 64'(mem_to_reg), 64'd0);
    check("dec_mask_rdst", 64'(reg_dst), 64'd0);
    check("dec_hold_alu", 64'(alu_out), 64'h61);

    // Saturation, then clear taking priority over a live increment
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    check("sat_clr0", 64'(stall_cnt), 64'd0);
    out_ready = 1'b0;
    drive(1'b1, 8'h02, 32'h70, 5'd1);
    step();
    drive(1'b0, 8'h00, 32'h0, 5'd0);
    repeat (20) step();
    check("sat_hold15", 64'(stall_cnt), 64'd15);
    clr_stats = 1'b1;
    step();
    check("sat_clr_wins", 64'(stall_cnt), 64'd0);
    clr_stats = 1'b0;
    step();
    check("sat_recount", 64'(stall_cnt), 64'd1);

    // Asynchronous reset with two beats held
    drive(1'b1, 8'h12, 32'h71, 5'd2);
    step();
    check("mrst_pre_occ", 64'(dbg_occ), 64'(OCC_TWO));
    #2 reset = 1'b0;
    #1;
    check("mrst_valid", 64'(out_valid), 64'd0);
    check("mrst_ready", 64'(in_ready), 64'd1);
    check("mrst_alu", 64'(alu_out), 64'd0);
    check("mrst_pc", 64'(pc_plus4), 64'd0);
    check("mrst_wdata", 64'(wdata), 64'd0);
    check("mrst_rd", 64'(rd), 64'd0);
    check("mrst_ctrl", 64'({reg_write, mem_read, mem_write, reg_dst, mem_to_reg}), 64'd0);
    check("mrst_fwd", 64'(fwd_valid), 64'd0);
    check("mrst_stall", 64'(stall_cnt), 64'd0);
    drive(1'b0, 8'h00, 32'h0, 5'd0);
    step();
    reset = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 8'h02, 32'h80, 5'd4);
    step();
    check("post_rst_alu", 64'(alu_out), 64'h80);
    drive(1'b0, 8'h00, 32'h0, 5'd0);
    step();
    check("post_rst_empty", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
